// File: rtl/prio_event_encoder_if.sv
// prio_event_encoder_if: request inputs and valid/ready index output of prio_event_encoder (mask_i only with MASK_EN)
interface prio_event_encoder_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
);
    logic [WIDTH-1:0] req_i;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic [WIDTH-1:0] pending_o;
`ifdef MASK_EN
    logic [WIDTH-1:0] mask_i;
    modport master (output req_i, out_ready, mask_i, input out_valid, out_idx, pending_o);
    modport slave  (input req_i, out_ready, mask_i, output out_valid, out_idx, pending_o);
`else
    modport master (output req_i, out_ready, input out_valid, out_idx, pending_o);
    modport slave  (input req_i, out_ready, output out_valid, out_idx, pending_o);
`endif
endinterface

// File: rtl/prio_event_encoder.sv
// prio_event_encoder: sticky pending events presented MSB-first on valid/ready; MASK_EN adds mask_i eligibility gating
module prio_event_encoder #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input logic                clk,
    input logic                rst_n,
    prio_event_encoder_if.slave bus
);
    logic [WIDTH-1:0] pending, pending_next, clr, elig;
    logic [IDX_W-1:0] idx_q, sel;
    logic             valid_q, acc, load;
    always_comb begin
        acc          = valid_q & bus.out_ready;
        clr          = acc ? WIDTH'(1) << idx_q : '0;
        pending_next = (pending & ~clr) | bus.req_i;
`ifdef MASK_EN
        elig         = pending_next & ~bus.mask_i;
`else
        elig         = pending_next;
`endif
        load         = !valid_q | bus.out_ready;
        sel          = '0;
        for (int i = 0; i < WIDTH; i++)
            if (elig[i]) sel = IDX_W'(i);
    end
    // a stalled output keeps its index even if higher bits arrive meanwhile
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            pending <= pending_next;
            if (load) begin
                valid_q <= |elig;
                idx_q   <= sel;
            end
        end
    end
    assign bus.out_valid = valid_q;
    assign bus.out_idx   = idx_q;
    assign bus.pending_o = pending;
endmodule

// File: tb/tb_prio_event_encoder.sv
// tb_prio_event_encoder: directed vector table, reset/mask sequences and a random run against a reference model
module tb_prio_event_encoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    always #5 clk = ~clk;
    prio_event_encoder_if #(.WIDTH(8)) bus();
    prio_event_encoder #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    typedef struct {
        logic [7:0] req;
        logic       ready;
        logic       v;
        logic [2:0] idx;
        logic [7:0] pend;
    } vec_t;
    vec_t tbl[17];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic drive(input logic [7:0] req, input logic ready, input logic [7:0] mask);
        bus.req_i     = req;
        bus.out_ready = ready;
`ifdef MASK_EN
        bus.mask_i    = mask;
`else
        if (mask != 8'h00) $display("mask ignored without MASK_EN");
`endif
    endtask
    task automatic step(input logic [7:0] req, input logic ready, input logic [7:0] mask);
        drive(req, ready, mask);
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic chk_out(input string name, input logic v, input logic [2:0] idx, input logic [7:0] pend);
        chk({name, "_valid"}, 32'(bus.out_valid), 32'(v));
        chk({name, "_idx"}, 32'(bus.out_idx), 32'(idx));
        chk({name, "_pend"}, 32'(bus.pending_o), 32'(pend));
    endtask
    function automatic logic [2:0] msb_of(input logic [7:0] x);
        int k = 7;
        while (k > 0 && !x[k]) k--;
        return 3'(k);
    endfunction
    logic [7:0] m_pend, m_clr, m_next, r_req;
    logic       m_valid, r_ready, m_acc;
    logic [2:0] m_idx, prev_idx;
    logic       stalled;
    initial begin
        drive(8'h00, 1'b0, 8'h00);
        repeat (2) @(negedge clk);
        chk_out("reset", 1'b0, 3'd0, 8'h00);
        rst_n = 1'b1;
        tbl[0]  = '{8'h05, 1'b1, 1'b1, 3'd2, 8'h05};
        tbl[1]  = '{8'h00, 1'b1, 1'b1, 3'd0, 8'h01};
        tbl[2]  = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00};
        tbl[3]  = '{8'h08, 1'b0, 1'b1, 3'd3, 8'h08};
        tbl[4]  = '{8'h80, 1'b0, 1'b1, 3'd3, 8'h88};
        tbl[5]  = '{8'h00, 1'b0, 1'b1, 3'd3, 8'h88};
        tbl[6]  = '{8'h00, 1'b1, 1'b1, 3'd7, 8'h80};
        tbl[7]  = '{8'h20, 1'b1, 1'b1, 3'd5, 8'h20};
        tbl[8]  = '{8'h20, 1'b1, 1'b1, 3'd5, 8'h20};
        tbl[9]  = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00};
        tbl[10] = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00};
        tbl[11] = '{8'h42, 1'b0, 1'b1, 3'd6, 8'h42};
        tbl[12] = '{8'h42, 1'b0, 1'b1, 3'd6, 8'h42};
        tbl[13] = '{8'h01, 1'b1, 1'b1, 3'd1, 8'h03};
        tbl[14] = '{8'h80, 1'b1, 1'b1, 3'd7, 8'h81};
        tbl[15] = '{8'h00, 1'b1, 1'b1, 3'd0, 8'h01};
        tbl[16] = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00};
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].req, tbl[i].ready, 8'h00);
            chk_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].idx, tbl[i].pend);
        end
        step(8'hFF, 1'b0, 8'h00);
        chk_out("pre_reset", 1'b1, 3'd7, 8'hFF);
        #2 rst_n = 1'b0;
        #1 chk_out("async_reset", 1'b0, 3'd0, 8'h00);
        @(negedge clk);
        drive(8'h00, 1'b0, 8'h00);
        rst_n = 1'b1;
`ifdef MASK_EN
        step(8'h81, 1'b0, 8'h80);
        chk_out("mask_sel", 1'b1, 3'd0, 8'h81);
        step(8'h00, 1'b1, 8'h80);
        chk_out("mask_acc", 1'b0, 3'd0, 8'h80);
        step(8'h00, 1'b0, 8'h00);
        chk_out("unmask", 1'b1, 3'd7, 8'h80);
        step(8'h00, 1'b0, 8'h80);
        chk_out("mask_no_retract", 1'b1, 3'd7, 8'h80);
        step(8'h00, 1'b1, 8'h00);
        chk_out("mask_done", 1'b0, 3'd0, 8'h00);
`endif
        m_pend = 8'h00; m_valid = 1'b0; m_idx = 3'd0;
        for (int c = 0; c < 1000; c++) begin
            r_req    = 8'($urandom & $urandom & $urandom);
            r_ready  = 1'($urandom_range(0, 2) != 0);
            stalled  = m_valid & !r_ready;
            prev_idx = m_idx;
            m_acc    = m_valid & r_ready;
            m_clr    = m_acc ? (8'h01 << m_idx) : 8'h00;
            m_next   = (m_pend & ~m_clr) | r_req;
            m_pend   = m_next;
            if (!m_valid || r_ready) begin
                m_valid = m_next != 8'h00;
                m_idx   = m_valid ? msb_of(m_next) : 3'd0;
            end
            step(r_req, r_ready, 8'h00);
            chk_out("rnd", m_valid, m_idx, m_pend);
            if (stalled) chk("rnd_stall_hold", 32'(bus.out_idx), 32'(prev_idx));
        end
        for (int c = 0; c < 16 && bus.out_valid; c++) begin
            m_idx = bus.out_idx;
            step(8'h00, 1'b1, 8'h00);
            if (bus.out_valid) chk("drain_desc", 32'(bus.out_idx < m_idx), 32'(1));
        end
        chk("drain_done", 32'(bus.out_valid), 32'(0));
        chk("drain_pend", 32'(bus.pending_o), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
